// File: rtl/dmux_sync_tx.sv
// Source-side front end of the data-mux CDC: registers each accepted word and flips src_toggle,
// then holds the bus until the resynchronised ack toggle returns (s_ready low while a word is outstanding).
module dmux_sync_tx #(
  parameter int   DEPTH   = 2,
  parameter int   WIDTH   = 8,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             ack_toggle,
  output logic             src_toggle,
  output logic [WIDTH-1:0] src_data,
  output logic             busy
);

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  logic [DEPTH-1:0] ack_sync_q, ack_sync_d;
  logic             ack_sync;
  logic             ack_dly_q, ack_dly_d;
  logic             ack_edge_q, ack_edge_d;

  logic [1:0]       state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             src_toggle_q, src_toggle_d;
  logic [WIDTH-1:0] src_data_q, src_data_d;

  // The edge detector is registered so the FSM only ever sees a clean one-cycle pulse.
  always_comb begin
    ack_sync_d = {ack_sync_q[DEPTH-2:0], ack_toggle};
    ack_sync   = ack_sync_q[DEPTH-1];
    ack_dly_d  = ack_sync;
    ack_edge_d = ack_sync ^ ack_dly_q;
  end

  always_comb begin
    state_d      = state_q;
    s_ready_d    = s_ready_q;
    busy_d       = busy_q;
    src_toggle_d = src_toggle_q;
    src_data_d   = src_data_q;
    case (state_q)
      ST_INIT: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b1;
      end
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          src_data_d   = s_data;
          src_toggle_d = ~src_toggle_q;
          s_ready_d    = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Bus stays frozen here; an acceptance is only possible once back in IDLE.
        if (ack_edge_q) begin
          state_d   = ST_IDLE;
          s_ready_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = ST_INIT;
        s_ready_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      ack_sync_q   <= '0;
      ack_dly_q    <= 1'b0;
      ack_edge_q   <= 1'b0;
      state_q      <= ST_INIT;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      src_toggle_q <= 1'b0;
      src_data_q   <= {WIDTH{RST_VAL}};
    end else begin
      ack_sync_q   <= ack_sync_d;
      ack_dly_q    <= ack_dly_d;
      ack_edge_q   <= ack_edge_d;
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      src_toggle_q <= src_toggle_d;
      src_data_q   <= src_data_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign src_toggle = src_toggle_q;
  assign src_data   = src_data_q;

endmodule
